// File: rtl/axis_bram_writer.sv
// Captures one AXI-Stream frame per arm into a single-port BRAM from address 0 and reports its length.
// Optional define AXIS_BRAM_WRITER_TKEEP_EN adds s_axis_tkeep, which then drives the byte write enables.
module axis_bram_writer #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    arm,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic                    s_axis_tvalid,
    input  logic                    s_axis_tlast,
`ifdef AXIS_BRAM_WRITER_TKEEP_EN
    input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
`endif
    output logic                    s_axis_tready,
    output logic [ADDR_WIDTH-1:0]   bram_addr,
    output logic [DATA_WIDTH-1:0]   bram_wrdata,
    output logic [DATA_WIDTH/8-1:0] bram_we,
    output logic                    bram_en,
    output logic                    bram_clk,
    output logic [ADDR_WIDTH-1:0]   count,
    output logic                    frame_done,
    output logic                    overflow,
    output logic                    busy
);

    localparam int WE_W = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0] LAST_PTR = {1'b0, {ADDR_WIDTH{1'b1}}};

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DRAIN, S_DONE} state_t;

    state_t                state, state_nx;
    logic [ADDR_WIDTH:0]   ptr;
    logic                  accepting;
    logic                  hs;
    logic                  wr;
    logic                  arm_ok;
    logic                  done_pend;
    logic [WE_W-1:0]       we_val;

    assign bram_clk      = aclk;
    assign bram_en       = aresetn;
    assign accepting     = (state == S_CAPTURE) || (state == S_DRAIN);
    assign s_axis_tready = accepting;
    assign busy          = accepting;
    assign hs            = s_axis_tvalid && accepting;
    assign wr            = hs && (state == S_CAPTURE);
    assign arm_ok        = arm && ((state == S_IDLE) || (state == S_DONE));

`ifdef AXIS_BRAM_WRITER_TKEEP_EN
    assign we_val = s_axis_tkeep;
`else
    assign we_val = {WE_W{1'b1}};
`endif

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= S_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE: if (arm) state_nx = S_CAPTURE;
            S_CAPTURE: begin
                if (hs) begin
                    if (s_axis_tlast)         state_nx = S_DONE;
                    else if (ptr == LAST_PTR) state_nx = S_DRAIN;
                end
            end
            S_DRAIN: if (hs && s_axis_tlast) state_nx = S_DONE;
            default: state_nx = S_IDLE;
        endcase
    end

    // count samples ptr one cycle after the last handshake, so the final write has already been presented
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ptr         <= '0;
            bram_addr   <= '0;
            bram_wrdata <= '0;
            bram_we     <= '0;
            count       <= '0;
            frame_done  <= 1'b0;
            done_pend   <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            done_pend  <= hs && s_axis_tlast;
            frame_done <= done_pend;
            if (done_pend) count <= ptr[ADDR_WIDTH-1:0];
            bram_we <= wr ? we_val : '0;
            if (wr) begin
                bram_addr   <= ptr[ADDR_WIDTH-1:0];
                bram_wrdata <= s_axis_tdata;
                ptr         <= ptr + 1'b1;
                if (!s_axis_tlast && ptr == LAST_PTR) overflow <= 1'b1;
            end
            if (arm_ok) begin
                ptr      <= '0;
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axis_bram_writer.sv
// Randomized bench for axis_bram_writer with a frame-level reference model and per-cycle monitor.
module tb_axis_bram_writer;

    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic          arm;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tlast;
`ifdef AXIS_BRAM_WRITER_TKEEP_EN
    logic [1:0]    s_axis_tkeep;
`endif
    logic          s_axis_tready;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_wrdata;
    logic [1:0]    bram_we;
    logic          bram_en;
    logic          bram_clk;
    logic [AW-1:0] count;
    logic          frame_done;
    logic          overflow;
    logic          busy;

    int vectors = 0;
    int miscompares = 0;

    axis_bram_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .aclk(aclk), .aresetn(aresetn), .arm(arm),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
`ifdef AXIS_BRAM_WRITER_TKEEP_EN
        .s_axis_tkeep(s_axis_tkeep),
`endif
        .s_axis_tready(s_axis_tready), .bram_addr(bram_addr), .bram_wrdata(bram_wrdata),
        .bram_we(bram_we), .bram_en(bram_en), .bram_clk(bram_clk), .count(count),
        .frame_done(frame_done), .overflow(overflow), .busy(busy)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: a frame is open between an accepted arm and its tlast beat; the
    // first DEPTH beats of a frame land at addresses 0.., the rest are dropped.
    bit          m_open, m_ovf;
    int          m_ptr, m_len, wr_cnt;
    logic [AW-1:0] m_count;
    bit          p1v, p2v, nw_v;
    logic [AW-1:0] p1c, p2c;
    int          nw_addr;
    logic [DW-1:0] nw_data;
    logic [1:0]  nw_we;

    always @(negedge aclk) begin
        if (!aresetn) begin
            chk("reset_outs", {s_axis_tready, bram_we, bram_addr, bram_wrdata, count,
                               frame_done, overflow, busy, bram_en}, 32'h0);
            m_open = 0; m_ovf = 0; m_ptr = 0; m_len = 0; m_count = '0;
            p1v = 0; p2v = 0; nw_v = 0;
        end else begin
            if (p2v) m_count = p2c;
            chk("tready", s_axis_tready, m_open);
            chk("busy", busy, m_open);
            chk("bram_en", bram_en, 1);
            chk("frame_done", frame_done, p2v);
            chk("count", count, m_count);
            chk("overflow", overflow, m_ovf);
            chk("write_active", bram_we != 2'b00, nw_v);
            if (nw_v) begin
                chk("wr_addr", bram_addr, nw_addr);
                chk("wr_data", bram_wrdata, nw_data);
                chk("wr_we", bram_we, nw_we);
            end
            if (bram_we != 2'b00) wr_cnt++;
            p2v = p1v; p2c = p1c; p1v = 0; nw_v = 0;
            if (m_open) begin
                if (s_axis_tvalid) begin
                    m_len++;
                    if (m_ptr < DEPTH) begin
                        nw_v = 1; nw_addr = m_ptr; nw_data = s_axis_tdata;
`ifdef AXIS_BRAM_WRITER_TKEEP_EN
                        nw_we = s_axis_tkeep;
`else
                        nw_we = 2'b11;
`endif
                        m_ptr++;
                    end
                    if (m_len == DEPTH && !s_axis_tlast) m_ovf = 1;
                    if (s_axis_tlast) begin
                        p1v = 1;
                        p1c = (m_len > DEPTH) ? '0 : AW'(m_len % DEPTH);
                        m_open = 0;
                    end
                end
            end else if (arm) begin
                m_open = 1; m_ptr = 0; m_len = 0; m_ovf = 0;
            end
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Ends in the cycle two after the tlast handshake, where frame_done must be high.
    task automatic send_frame(input int n, input int gap_pct, input bit do_arm,
                              input bit noise_arm, input bit seq);
        int w0;
        logic [AW-1:0] exp_cnt;
        w0 = wr_cnt;
        if (do_arm) begin
            arm = 1; tick(); arm = 0;
        end
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < 3 && $urandom_range(0, 99) < gap_pct; g++) begin
                s_axis_tvalid = 0;
                arm = noise_arm && $urandom_range(0, 1) == 1;
                tick();
            end
            s_axis_tvalid = 1;
            s_axis_tdata  = seq ? DW'(i + 1) : DW'($urandom);
            s_axis_tlast  = (i == n - 1);
`ifdef AXIS_BRAM_WRITER_TKEEP_EN
            s_axis_tkeep  = (i == 0) ? 2'b01 : 2'($urandom);
`endif
            arm = noise_arm && $urandom_range(0, 1) == 1;
            tick();
        end
        s_axis_tvalid = 0; s_axis_tlast = 0; arm = 0;
        tick();
        exp_cnt = (n > DEPTH) ? '0 : AW'(n % DEPTH);
        chk("done_at_n2", frame_done, 1);
        chk("frame_count", count, exp_cnt);
        chk("frame_ovf", overflow, n > DEPTH);
        chk("frame_writes", wr_cnt - w0, (n > DEPTH) ? DEPTH : n);
    endtask

    task automatic idle_beats(input int k);
        for (int i = 0; i < k; i++) begin
            s_axis_tvalid = 1; s_axis_tdata = DW'($urandom); s_axis_tlast = $urandom_range(0, 1) == 1;
            tick();
        end
        s_axis_tvalid = 0; s_axis_tlast = 0;
    endtask

    initial begin
        aresetn = 0; arm = 0; s_axis_tdata = '0; s_axis_tvalid = 0; s_axis_tlast = 0;
`ifdef AXIS_BRAM_WRITER_TKEEP_EN
        s_axis_tkeep = 2'b11;
`endif
        wr_cnt = 0;
        repeat (3) tick();
        aresetn = 1;
        tick();
        idle_beats(3);

        send_frame(5, 0, 1, 0, 1);
        tick(); tick();
        send_frame(16, 0, 1, 0, 0);
        send_frame(20, 0, 1, 0, 0);
        arm = 1; tick(); arm = 0;
        chk("arm_clears_ovf", overflow, 0);
        chk("count_holds", count, 0);
        send_frame(3, 0, 0, 0, 0);

        // arm coinciding with frame_done
        arm = 1; tick(); arm = 0;
        chk("arm_on_done", s_axis_tready, 1);
        send_frame(7, 40, 0, 1, 0);
        idle_beats(2);

        for (int f = 0; f < 8; f++) begin
            send_frame($urandom_range(1, 22), 30, 1, 1, 0);
            idle_beats($urandom_range(0, 2));
        end

        // reset dropped mid-frame, right after the third beat is accepted
        arm = 1; tick(); arm = 0;
        for (int i = 0; i < 3; i++) begin
            s_axis_tvalid = 1; s_axis_tdata = DW'($urandom); tick();
        end
        s_axis_tvalid = 0;
        #1 aresetn = 0;
        #1 chk("async_rst", {s_axis_tready, bram_we, bram_addr, bram_wrdata, count,
                             frame_done, overflow, busy, bram_en}, 32'h0);
        tick();
        aresetn = 1;
        idle_beats(2);
        chk("post_rst_tready", s_axis_tready, 0);
        chk("post_rst_count", count, 0);
        send_frame(9, 20, 1, 0, 0);
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
